// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared types and constants for the WS2812/SK6812 strip driver.
//   state_e         - controller states
//   COLOR_GRB/RGB   - colour-order selector values
//   TBIT_CYC etc.   - default bit/latch timing at a 12 MHz clock
//   pack_pixel      - builds the MSB-aligned 32-bit shift word for one pixel
package ws2812_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_WAIT,
    ST_LATCH
  } state_e;

  localparam int COLOR_GRB = 0;
  localparam int COLOR_RGB = 1;

  localparam int TBIT_CYC = 15;    // 1.25 us
  localparam int T0H_CYC  = 4;
  localparam int T1H_CYC  = 8;
  localparam int TRST_CYC = 3600;  // 300 us

  // The word is left-aligned so the next bit to send is always bit 31,
  // whatever the pixel width; the low byte is zero for 24-bit pixels.
  function automatic logic [31:0] pack_pixel(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b,
                                             input logic [7:0] w,
                                             input logic       order_rgb,
                                             input logic       rgbw);
    logic [23:0] rgb;
    rgb = order_rgb ? {r, g, b} : {g, r, b};
    return {rgb, (rgbw ? w : 8'h00)};
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder: high/low waveform for one NRZ bit.
//   clk, rst_n  - clock, async active-low reset
//   start_i     - begin a bit this cycle (may retrigger on the last cycle)
//   bit_i       - value of the bit being started
//   high_o      - waveform level, high for T1H/T0H cycles from the start
//   fall_o      - last high cycle of the bit
//   done_o      - last cycle of the bit period
module ws2812_bit_encoder #(
  parameter int TBIT_CYC = 15,
  parameter int T0H_CYC  = 4,
  parameter int T1H_CYC  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic bit_i,
  output logic high_o,
  output logic fall_o,
  output logic done_o
);
  import ws2812_pkg::*;

  localparam int CW = $clog2(TBIT_CYC);

  logic [CW-1:0] cnt_q;
  logic          bit_q;
  logic          active_q;
  logic [CW-1:0] fall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      bit_q    <= 1'b0;
      active_q <= 1'b0;
    end else if (start_i) begin
      cnt_q    <= CW'(TBIT_CYC - 1);
      bit_q    <= bit_i;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) active_q <= 1'b0;
      else             cnt_q    <= cnt_q - CW'(1);
    end
  end

  // Down-counter value on the last high cycle of the bit.
  assign fall_cnt = bit_q ? CW'(TBIT_CYC - T1H_CYC) : CW'(TBIT_CYC - T0H_CYC);

  assign high_o = active_q && (cnt_q >= fall_cnt);
  assign fall_o = active_q && (cnt_q == fall_cnt);
  assign done_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/ws2812_strip_driver.sv
// ws2812_strip_driver: serialises a pixel stream onto a WS2812/SK6812 line.
//   clk, rst_n          - clock, async active-low reset
//   pix_valid/pix_ready - pixel handshake into a one-entry holding register
//   pix_r/g/b/w         - colour channels (w ignored when RGBW = 0)
//   pix_last            - end the frame after this pixel
//   d_out               - registered serial output
//   busy                - registered, high when not IDLE (one-cycle lag)
//   frame_done          - pulse when the latch gap completes
//   underrun            - pulse when a mid-frame stall is abandoned
//
// state | meaning
// IDLE  | line low, waiting for the first pixel of a frame
// HIGH  | high phase of the current bit
// LOW   | low phase, remainder of the bit period
// WAIT  | mid-frame stall, line low, bounded by TRST_CYC
// LATCH | end-of-frame latch gap, line low for TRST_CYC
module ws2812_strip_driver #(
  parameter int NUM_PIXELS  = 8,
  parameter int RGBW        = 0,
  parameter int COLOR_ORDER = 0,
  parameter int TBIT_CYC    = ws2812_pkg::TBIT_CYC,
  parameter int T0H_CYC     = ws2812_pkg::T0H_CYC,
  parameter int T1H_CYC     = ws2812_pkg::T1H_CYC,
  parameter int TRST_CYC    = ws2812_pkg::TRST_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  input  logic [7:0] pix_w,
  input  logic       pix_last,
  output logic       d_out,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);
  import ws2812_pkg::*;

  localparam int BPP = 24 + 8 * RGBW;
  localparam int IW  = $clog2(NUM_PIXELS + 1);
  localparam int GW  = $clog2(TRST_CYC + 1);

  state_e        state_q;
  logic [31:0]   hold_word_q, shift_q;
  logic          hold_last_q, hold_full_q, hold_full_d, cur_last_q;
  logic [4:0]    bits_left_q;
  logic [IW-1:0] idx_q;
  logic [GW-1:0] gap_q;
  logic          d_out_q, busy_q, frame_done_q, underrun_q;

  logic accept, load_go, shift_go, eof;
  logic enc_start, enc_bit, enc_high, enc_fall, enc_done;

  assign accept = pix_valid && !hold_full_q;
  assign eof    = (idx_q == IW'(NUM_PIXELS - 1)) || cur_last_q;

  always_comb begin
    load_go  = 1'b0;
    shift_go = 1'b0;
    case (state_q)
      ST_IDLE: load_go = hold_full_q;
      ST_LOW: begin
        if (enc_done) begin
          if (bits_left_q != 5'd0)       shift_go = 1'b1;
          else if (!eof && hold_full_q)  load_go  = 1'b1;
        end
      end
      ST_WAIT: load_go = hold_full_q;
      default: ;
    endcase
  end

  // Accept and load are exclusive: accept needs the register empty,
  // load needs it full.
  always_comb begin
    hold_full_d = hold_full_q;
    if (accept)       hold_full_d = 1'b1;
    else if (load_go) hold_full_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full_q <= 1'b0;
      hold_word_q <= '0;
      hold_last_q <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      if (accept) begin
        hold_word_q <= pack_pixel(pix_r, pix_g, pix_b, pix_w,
                                  COLOR_ORDER == COLOR_RGB, RGBW != 0);
        hold_last_q <= pix_last;
      end
    end
  end

  assign enc_start = load_go || shift_go;
  assign enc_bit   = load_go ? hold_word_q[31] : shift_q[30];

  ws2812_bit_encoder #(
    .TBIT_CYC (TBIT_CYC),
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC)
  ) u_enc (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (enc_start),
    .bit_i   (enc_bit),
    .high_o  (enc_high),
    .fall_o  (enc_fall),
    .done_o  (enc_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      cur_last_q   <= 1'b0;
      bits_left_q  <= '0;
      idx_q        <= '0;
      gap_q        <= '0;
      d_out_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      busy_q       <= (state_q != ST_IDLE);
      d_out_q      <= enc_high;

      if (load_go) begin
        shift_q     <= hold_word_q;
        cur_last_q  <= hold_last_q;
        bits_left_q <= 5'(BPP - 1);
      end else if (shift_go) begin
        shift_q     <= shift_q << 1;
        bits_left_q <= bits_left_q - 5'd1;
      end

      case (state_q)
        ST_IDLE: if (load_go) state_q <= ST_HIGH;
        ST_HIGH: if (enc_fall) state_q <= ST_LOW;
        ST_LOW: begin
          if (enc_done) begin
            if (shift_go) begin
              state_q <= ST_HIGH;
            end else if (eof) begin
              state_q <= ST_LATCH;
              gap_q   <= GW'(TRST_CYC - 1);
            end else if (load_go) begin
              state_q <= ST_HIGH;
              idx_q   <= idx_q + IW'(1);
            end else begin
              state_q <= ST_WAIT;
              gap_q   <= GW'(TRST_CYC - 1);
            end
          end
        end
        ST_WAIT: begin
          if (load_go) begin
            state_q <= ST_HIGH;
            idx_q   <= idx_q + IW'(1);
          end else if (gap_q == '0) begin
            // Stall outlasted the latch time: the strip has already
            // latched a partial frame, so restart counting from pixel 0.
            state_q    <= ST_IDLE;
            underrun_q <= 1'b1;
            idx_q      <= '0;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        ST_LATCH: begin
          if (gap_q == '0) begin
            state_q      <= ST_IDLE;
            frame_done_q <= 1'b1;
            idx_q        <= '0;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pix_ready  = !hold_full_q;
  assign d_out      = d_out_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule
